// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: RAM size/direction codes,
// requester ids, FSM state encoding and the alignment rule.
package data_mem_arbiter_pkg;

  // ram_512x8 Size encoding
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // ram_512x8 ReadWrite encoding
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Requester ids; also the bit index into the req/grant vectors
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // High when the access must not reach the RAM.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker.
//   req[1:0]  requests, indexed by port id
//   ptr       port that wins a tie
//   advance   arbitration is being taken this cycle
//   grant     one-hot winner (zero when no request)
//   ptr_nxt   pointer for the next cycle; only a tie moves it, to the loser
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr_nxt
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // A single requester does not disturb fairness; only ties rotate.
  assign ptr_nxt = (advance && (&req)) ? ~ptr : ptr;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares ram_512x8 between instruction fetch (word reads) and load/store.
// One transaction = IDLE (grant + latch fields) -> ACCESS (mem_en) -> DONE
// (done pulse with registered read data), 3 cycles.
//   clk, reset              clock, synchronous active-high reset
//   if_req/if_addr          IF request (implicit word read)
//   if_rdata/if_done/if_err IF response, valid while if_done
//   ls_req/rw/size/se/addr/wdata  LS request
//   ls_rdata/ls_done/ls_err LS response, valid while ls_done
//   mem_*                   registered RAM controls; mem_dout is RAM DataOut
//   busy                    transaction in flight
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [1:0]        ls_size,
  input  logic              ls_se,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic              mem_se,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  state_t     state;
  logic       rr_ptr, ptr_nxt;
  logic [1:0] req, grant;
  logic       idle;
  logic       win;   // port owning the current transaction
  logic       bad;   // current transaction is misaligned / illegal
  logic       if_bad, ls_bad;

  assign req    = {ls_req, if_req};
  assign idle   = (state == ST_IDLE);
  assign busy   = !idle;
  assign if_bad = misaligned(SZ_WORD, if_addr[1:0]);
  assign ls_bad = misaligned(ls_size, ls_addr[1:0]);

  rr_arb2 u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .advance (idle),
    .grant   (grant),
    .ptr_nxt (ptr_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= PORT_LS;
      win      <= PORT_IF;
      bad      <= 1'b0;
      mem_en   <= 1'b0;
      mem_rw   <= RW_READ;
      mem_se   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_size <= SZ_BYTE;
      if_rdata <= '0;
      if_done  <= 1'b0;
      if_err   <= 1'b0;
      ls_rdata <= '0;
      ls_done  <= 1'b0;
      ls_err   <= 1'b0;
    end else begin
      rr_ptr <= ptr_nxt;
      case (state)
        ST_IDLE: begin
          if (grant[PORT_LS]) begin
            win      <= PORT_LS;
            bad      <= ls_bad;
            mem_en   <= !ls_bad;
            mem_rw   <= ls_rw;
            mem_se   <= ls_se;
            mem_addr <= ls_addr;
            mem_din  <= ls_wdata;
            mem_size <= ls_size;
            state    <= ST_ACCESS;
          end else if (grant[PORT_IF]) begin
            win      <= PORT_IF;
            bad      <= if_bad;
            mem_en   <= !if_bad;
            mem_rw   <= RW_READ;
            mem_se   <= 1'b0;
            mem_addr <= if_addr;
            mem_din  <= '0;
            mem_size <= SZ_WORD;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // DataOut is combinational off the registered controls, so it is
          // valid here and captured on this edge.
          mem_en <= 1'b0;
          state  <= ST_DONE;
          if (win == PORT_LS) begin
            ls_done  <= 1'b1;
            ls_err   <= bad;
            ls_rdata <= (bad || mem_rw == RW_WRITE) ? '0 : mem_dout;
          end else begin
            if_done  <= 1'b1;
            if_err   <= bad;
            if_rdata <= bad ? '0 : mem_dout;
          end
        end
        ST_DONE: begin
          if_done <= 1'b0;
          if_err  <= 1'b0;
          ls_done <= 1'b0;
          ls_err  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
